// File: rtl/des_pkg.sv
// Shared types and defaults for the DES block sequencer.
package des_pkg;

  localparam int unsigned BLOCK_W         = 64;
  localparam int unsigned DEF_TIMEOUT_CYC = 1023;

  typedef logic [BLOCK_W-1:0] des_block_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    KICK,
    WAIT_CORE,
    DRAIN,
    FINISH
  } seq_state_t;

endpackage

// File: rtl/des_cbc_chain.sv
// CBC chaining: holds the chain value and applies the pre-core / post-core XOR.
// Encrypt XORs the chain into the message and chains on the core result;
// decrypt XORs the chain into the result and chains on the ciphertext sent.
module des_cbc_chain
  import des_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dir,
  input  des_block_t iv,
  input  des_block_t in_block,
  input  des_block_t sent,
  input  des_block_t result,
  input  logic       take_out,
  output des_block_t message_c,
  output des_block_t out_c
);

  des_block_t chain;

  // Chain register: IV at job start, advanced once per completed block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else if (load) begin
      chain <= iv;
    end else if (take_out) begin
      chain <= dir ? sent : result;
    end
  end

  // Direction-dependent XOR placement around the core.
  always_comb begin
    message_c = dir ? in_block : (in_block ^ chain);
    out_c     = dir ? (result ^ chain) : result;
  end

endmodule

// File: rtl/des_block_sequencer.sv
// Streams a job of N 64-bit blocks through one DES core, one block at a time.
// Build option: CBC_MODE_EN enables CBC chaining (default build is ECB).
module des_block_sequencer
  import des_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_blocks,
  input  logic [63:0]      key_in,
  input  logic             decrypt_mode,
  input  logic [63:0]      iv_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [63:0]      core_message,
  output logic [63:0]      core_key,
  output logic             core_dir,
  output logic             core_enable,
  input  logic             core_done,
  input  logic [63:0]      core_result,
  output logic             core_ack,
  output logic             busy,
  output logic             job_done,
  output logic [CNT_W-1:0] blocks_done,
  output logic             error
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  seq_state_t       state;
  logic [CNT_W-1:0] num_r;
  logic [TO_W-1:0]  to_cnt;
  des_block_t       msg_c;
  des_block_t       res_c;

`ifdef CBC_MODE_EN
  logic accept_c;
  logic take_out_c;

  assign accept_c   = (state == IDLE) && start;
  assign take_out_c = (state == WAIT_CORE) && core_done;

  des_cbc_chain u_chain (
    .clk       (clk),
    .rst       (reset),
    .load      (accept_c),
    .dir       (core_dir),
    .iv        (iv_in),
    .in_block  (in_data),
    .sent      (core_message),
    .result    (core_result),
    .take_out  (take_out_c),
    .message_c (msg_c),
    .out_c     (res_c)
  );
`else
  logic unused_iv;

  assign unused_iv = ^iv_in;
  assign msg_c     = in_data;
  assign res_c     = core_result;
`endif

  // Job FSM with all handshake and status outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      num_r        <= '0;
      to_cnt       <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      core_message <= '0;
      core_key     <= '0;
      core_dir     <= 1'b0;
      core_enable  <= 1'b0;
      core_ack     <= 1'b0;
      busy         <= 1'b0;
      job_done     <= 1'b0;
      blocks_done  <= '0;
      error        <= 1'b0;
    end else begin
      core_enable <= 1'b0;
      core_ack    <= 1'b0;
      job_done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            num_r       <= num_blocks;
            core_key    <= key_in;
            core_dir    <= decrypt_mode;
            error       <= 1'b0;
            blocks_done <= '0;
            busy        <= 1'b1;
            if (num_blocks != '0) begin
              in_ready <= 1'b1;
              state    <= FETCH;
            end else begin
              state <= FINISH;
            end
          end
        end
        FETCH: begin
          if (in_valid) begin
            core_message <= msg_c;
            in_ready     <= 1'b0;
            state        <= KICK;
          end
        end
        KICK: begin
          // Hold off while the core still shows the previous result.
          if (!core_done) begin
            core_enable <= 1'b1;
            to_cnt      <= '0;
            state       <= WAIT_CORE;
          end
        end
        WAIT_CORE: begin
          if (core_done) begin
            out_data  <= res_c;
            core_ack  <= 1'b1;
            out_valid <= 1'b1;
            state     <= DRAIN;
          end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            error    <= 1'b1;
            core_ack <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            blocks_done <= blocks_done + 1'b1;
            if (CNT_W'(blocks_done + 1'b1) == num_r) begin
              state <= FINISH;
            end else begin
              in_ready <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        FINISH: begin
          job_done <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
